// File: rtl/mem_req_bridge_if.sv
// Bus bundles for mem_req_bridge.
//   mem_req_bridge_req_if : level-held request side (test state machine <-> bridge)
//   mem_req_bridge_avm_if : single-beat Avalon-MM side (bridge <-> DDR3 controller)
// In both bundles the master modport is the side that starts a transaction.

interface mem_req_bridge_req_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int WORD_WIDTH = 64
);
    logic                  req_read;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [WORD_WIDTH-1:0] req_wdata;
    logic                  confirm;
    logic [WORD_WIDTH-1:0] rd_data;

    modport master (
        output req_read, req_write, req_address, req_wdata,
        input  confirm, rd_data
    );

    modport slave (
        input  req_read, req_write, req_address, req_wdata,
        output confirm, rd_data
    );
endinterface

interface mem_req_bridge_avm_if #(
    parameter int AVM_ADDR_WIDTH = 26,
    parameter int WORD_WIDTH     = 64
);
    logic [AVM_ADDR_WIDTH-1:0] avm_address;
    logic                      avm_read;
    logic                      avm_write;
    logic [WORD_WIDTH-1:0]     avm_writedata;
    logic [WORD_WIDTH/8-1:0]   avm_byteenable;
    logic                      avm_burstcount;
    logic                      avm_waitrequest;
    logic [WORD_WIDTH-1:0]     avm_readdata;
    logic                      avm_readdatavalid;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
               avm_byteenable, avm_burstcount,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
               avm_byteenable, avm_burstcount,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/mem_req_bridge.sv
// mem_req_bridge: turns level-held read/write requests from the hammer/test
// state machine into single-beat Avalon-MM transactions, returns a one-cycle
// confirm pulse with the read-back word, abandons reads that exceed
// TIMEOUT_CYCLES of waiting, and keeps sticky timeout/protocol error flags.
// Optional transaction statistics are built when MEM_REQ_BRIDGE_STATS_EN is
// defined; otherwise wr_count, rd_count and max_rd_latency are tied to 0.

module mem_req_bridge #(
    parameter int ADDR_WIDTH     = 64,
    parameter int WORD_WIDTH     = 64,
    parameter int AVM_ADDR_WIDTH = 26,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_req_bridge_req_if.slave  req,
    mem_req_bridge_avm_if.master avm,
    output logic                 timeout_err,
    output logic                 proto_err,
    output logic [2:0]           bridge_state,
    output logic [31:0]          wr_count,
    output logic [31:0]          rd_count,
    output logic [15:0]          max_rd_latency
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_WR = 3'd1,
        ISSUE_RD = 3'd2,
        WAIT_RD  = 3'd3,
        DONE     = 3'd4
    } state_t;

    // Timer holds completed WAIT_RD cycles; elapsed includes the current one,
    // so it tops out at exactly TIMEOUT_CYCLES.
    localparam int                 TIMER_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(TIMEOUT_CYCLES);

    state_t                    state;
    state_t                    state_next;
    logic [TIMER_W-1:0]        timer;
    logic [TIMER_W-1:0]        elapsed;
    logic                      rd_arrived;
    logic                      rd_timeout;
    logic                      confirm_c;
    logic                      avm_read_c;
    logic                      avm_write_c;
    logic [AVM_ADDR_WIDTH-1:0] avm_addr_reg;
    logic [WORD_WIDTH-1:0]     avm_wdata_reg;
    logic [WORD_WIDTH-1:0]     rd_word;

    // Address bits above the Avalon word address are intentionally dropped.
    generate
        if (ADDR_WIDTH > AVM_ADDR_WIDTH) begin : g_addr_trunc
            logic unused_addr_hi;
            assign unused_addr_hi = ^req.req_address[ADDR_WIDTH-1:AVM_ADDR_WIDTH];
        end
    endgenerate

    assign elapsed    = timer + 1'b1;
    assign rd_arrived = (state == WAIT_RD) && avm.avm_readdatavalid;
    // Data arriving on the timeout cycle wins over the timeout.
    assign rd_timeout = (state == WAIT_RD) && !avm.avm_readdatavalid && (elapsed == TIMEOUT_VAL);

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state Avalon strobes / confirm pulse.
    always_comb begin
        state_next  = state;
        avm_read_c  = 1'b0;
        avm_write_c = 1'b0;
        confirm_c   = 1'b0;
        case (state)
            IDLE: begin
                if (req.req_write) begin
                    state_next = ISSUE_WR;
                end else if (req.req_read) begin
                    state_next = ISSUE_RD;
                end
            end
            ISSUE_WR: begin
                avm_write_c = 1'b1;
                if (!avm.avm_waitrequest) begin
                    state_next = DONE;
                end
            end
            ISSUE_RD: begin
                avm_read_c = 1'b1;
                if (!avm.avm_waitrequest) begin
                    state_next = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (avm.avm_readdatavalid || rd_timeout) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                confirm_c  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read latency timer: cleared while the read is being issued, counts in WAIT_RD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (state == ISSUE_RD) begin
            timer <= '0;
        end else if (state == WAIT_RD) begin
            timer <= elapsed;
        end
    end

    // Request latching, read-data capture and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_addr_reg  <= '0;
            avm_wdata_reg <= '0;
            rd_word       <= '0;
            timeout_err   <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (req.req_write) begin
                    avm_addr_reg  <= req.req_address[AVM_ADDR_WIDTH-1:0];
                    avm_wdata_reg <= req.req_wdata;
                    if (req.req_read) begin
                        proto_err <= 1'b1;
                    end
                end else if (req.req_read) begin
                    avm_addr_reg <= req.req_address[AVM_ADDR_WIDTH-1:0];
                end
            end
            if (rd_arrived) begin
                rd_word <= avm.avm_readdata;
            end
            if (rd_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef MEM_REQ_BRIDGE_STATS_EN
    logic        wr_done;
    logic        rd_done;
    logic [15:0] latency_now;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat16(input logic [31:0] v);
        return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
    endfunction

    // Counted on the transition into DONE so the value is current at confirm.
    assign wr_done     = (state == ISSUE_WR) && !avm.avm_waitrequest;
    assign rd_done     = rd_arrived || rd_timeout;
    assign latency_now = sat16(32'(elapsed));

    // Saturating transaction counters and worst observed read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count       <= '0;
            rd_count       <= '0;
            max_rd_latency <= '0;
        end else begin
            if (wr_done) begin
                wr_count <= sat_inc32(wr_count);
            end
            if (rd_done) begin
                rd_count <= sat_inc32(rd_count);
            end
            if (rd_arrived && (latency_now > max_rd_latency)) begin
                max_rd_latency <= latency_now;
            end
        end
    end
`else
    assign wr_count       = '0;
    assign rd_count       = '0;
    assign max_rd_latency = '0;
`endif

    assign req.confirm         = confirm_c;
    assign req.rd_data         = rd_word;
    assign avm.avm_address     = avm_addr_reg;
    assign avm.avm_writedata   = avm_wdata_reg;
    assign avm.avm_read        = avm_read_c;
    assign avm.avm_write       = avm_write_c;
    assign avm.avm_byteenable  = '1;
    assign avm.avm_burstcount  = 1'b1;
    assign bridge_state        = state;

endmodule

// File: tb/tb_mem_req_bridge.sv
// Directed testbench for mem_req_bridge (TIMEOUT_CYCLES = 16).
// Expected statistics are masked to 0 unless MEM_REQ_BRIDGE_STATS_EN is defined.

module tb_mem_req_bridge;

    localparam int ADDR_WIDTH     = 64;
    localparam int WORD_WIDTH     = 64;
    localparam int AVM_ADDR_WIDTH = 26;
    localparam int TIMEOUT_CYCLES = 16;

`ifdef MEM_REQ_BRIDGE_STATS_EN
    localparam logic [63:0] STAT_MASK = '1;
`else
    localparam logic [63:0] STAT_MASK = '0;
`endif

    logic        clk;
    logic        reset_n;
    logic        timeout_err;
    logic        proto_err;
    logic [2:0]  bridge_state;
    logic [31:0] wr_count;
    logic [31:0] rd_count;
    logic [15:0] max_rd_latency;

    int checks   = 0;
    int failures = 0;

    mem_req_bridge_req_if #(.ADDR_WIDTH(ADDR_WIDTH), .WORD_WIDTH(WORD_WIDTH)) req_bus ();
    mem_req_bridge_avm_if #(.AVM_ADDR_WIDTH(AVM_ADDR_WIDTH), .WORD_WIDTH(WORD_WIDTH)) avm_bus ();

    mem_req_bridge #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .WORD_WIDTH    (WORD_WIDTH),
        .AVM_ADDR_WIDTH(AVM_ADDR_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req_bus),
        .avm           (avm_bus),
        .timeout_err   (timeout_err),
        .proto_err     (proto_err),
        .bridge_state  (bridge_state),
        .wr_count      (wr_count),
        .rd_count      (rd_count),
        .max_rd_latency(max_rd_latency)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] stat(input logic [63:0] v);
        return v & STAT_MASK;
    endfunction

    // Waits (bounded) for confirm, sampling on falling edges; cycles counts negedges.
    task automatic wait_confirm(input int limit, output int cycles, output logic seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (req_bus.confirm) seen = 1'b1;
        end
    endtask

    // Issue a request at the current negedge and wait for its confirm, then drop it.
    task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input string tag);
        int   cyc;
        logic seen;
        req_bus.req_write   = 1'b1;
        req_bus.req_address = addr;
        req_bus.req_wdata   = data;
        wait_confirm(20, cyc, seen);
        check_eq({tag, "_confirm"}, 64'(seen), 64'd1);
        req_bus.req_write = 1'b0;
    endtask

    initial begin
        int   cyc;
        logic seen;

        reset_n                   = 1'b0;
        req_bus.req_read          = 1'b0;
        req_bus.req_write         = 1'b0;
        req_bus.req_address       = '0;
        req_bus.req_wdata         = '0;
        avm_bus.avm_waitrequest   = 1'b0;
        avm_bus.avm_readdata      = '0;
        avm_bus.avm_readdatavalid = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check_eq("rst_state",   64'(bridge_state), 64'd0);
        check_eq("rst_confirm", 64'(req_bus.confirm), 64'd0);
        check_eq("rst_rdwr",    64'({avm_bus.avm_read, avm_bus.avm_write}), 64'd0);
        check_eq("rst_rd_data", req_bus.rd_data, 64'd0);
        check_eq("rst_addr",    64'(avm_bus.avm_address), 64'd0);
        check_eq("rst_wdata",   avm_bus.avm_writedata, 64'd0);
        check_eq("rst_errs",    64'({timeout_err, proto_err}), 64'd0);
        check_eq("rst_counts",  {wr_count, rd_count}, 64'd0);
        check_eq("rst_maxlat",  64'(max_rd_latency), 64'd0);
        check_eq("byteenable",  64'(avm_bus.avm_byteenable), 64'hFF);
        check_eq("burstcount",  64'(avm_bus.avm_burstcount), 64'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // ---------------- write, no stall ----------------
        req_bus.req_write   = 1'b1;
        req_bus.req_address = 64'h1234;
        req_bus.req_wdata   = 64'hA5A5_A5A5_A5A5_A5A5;
        @(negedge clk);
        check_eq("w0_avm_write", 64'(avm_bus.avm_write), 64'd1);
        check_eq("w0_avm_read",  64'(avm_bus.avm_read), 64'd0);
        check_eq("w0_addr",      64'(avm_bus.avm_address), 64'h1234);
        check_eq("w0_wdata",     avm_bus.avm_writedata, 64'hA5A5_A5A5_A5A5_A5A5);
        check_eq("w0_no_confirm_c1", 64'(req_bus.confirm), 64'd0);
        @(negedge clk);
        check_eq("w0_confirm_c2", 64'(req_bus.confirm), 64'd1);
        check_eq("w0_write_low",  64'(avm_bus.avm_write), 64'd0);
        check_eq("w0_wr_count",   64'(wr_count), stat(64'd1));
        req_bus.req_write = 1'b0;
        @(negedge clk);
        check_eq("w0_confirm_once", 64'(req_bus.confirm), 64'd0);
        check_eq("w0_idle",         64'(bridge_state), 64'd0);

        // ---------------- write with 3-cycle waitrequest, truncated address ----------------
        req_bus.req_write       = 1'b1;
        req_bus.req_address     = 64'hABCD_EF00_0765_4321;
        req_bus.req_wdata       = 64'h0123_4567_89AB_CDEF;
        avm_bus.avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("w1_hold_write_%0d", i), 64'(avm_bus.avm_write), 64'd1);
            check_eq($sformatf("w1_hold_addr_%0d", i),  64'(avm_bus.avm_address), 64'h365_4321);
            check_eq($sformatf("w1_hold_data_%0d", i),  avm_bus.avm_writedata, 64'h0123_4567_89AB_CDEF);
            check_eq($sformatf("w1_hold_noconf_%0d", i), 64'(req_bus.confirm), 64'd0);
            if (i == 0) req_bus.req_wdata = 64'hFFFF_0000_FFFF_0000;
            if (i == 3) avm_bus.avm_waitrequest = 1'b0;
        end
        @(negedge clk);
        check_eq("w1_confirm",  64'(req_bus.confirm), 64'd1);
        check_eq("w1_wr_count", 64'(wr_count), stat(64'd2));
        req_bus.req_write = 1'b0;
        @(negedge clk);
        check_eq("w1_confirm_once", 64'(req_bus.confirm), 64'd0);

        // ---------------- read, data 5 cycles after acceptance ----------------
        req_bus.req_read    = 1'b1;
        req_bus.req_address = 64'h40;
        @(negedge clk);
        check_eq("r0_avm_read", 64'(avm_bus.avm_read), 64'd1);
        check_eq("r0_state",    64'(bridge_state), 64'd2);
        check_eq("r0_addr",     64'(avm_bus.avm_address), 64'h40);
        avm_bus.avm_readdatavalid = 1'b1;
        avm_bus.avm_readdata      = 64'h1357_9BDF_2468_ACE0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            check_eq($sformatf("r0_wait_state_c%0d", c), 64'(bridge_state), 64'd3);
            check_eq($sformatf("r0_wait_noconf_c%0d", c), 64'(req_bus.confirm), 64'd0);
            if (c == 2) begin
                check_eq("r0_issue_valid_ignored", req_bus.rd_data, 64'd0);
                avm_bus.avm_readdatavalid = 1'b0;
            end
            if (c == 6) begin
                avm_bus.avm_readdatavalid = 1'b1;
                avm_bus.avm_readdata      = 64'hDEAD_BEEF_0000_FFFF;
            end
        end
        @(negedge clk);
        avm_bus.avm_readdatavalid = 1'b0;
        check_eq("r0_confirm",  64'(req_bus.confirm), 64'd1);
        check_eq("r0_rd_data",  req_bus.rd_data, 64'hDEAD_BEEF_0000_FFFF);
        check_eq("r0_maxlat",   64'(max_rd_latency), stat(64'd5));
        check_eq("r0_rd_count", 64'(rd_count), stat(64'd1));
        check_eq("r0_no_tmo",   64'(timeout_err), 64'd0);
        req_bus.req_read = 1'b0;
        @(negedge clk);

        // ---------------- read timeout ----------------
        req_bus.req_read    = 1'b1;
        req_bus.req_address = 64'h80;
        wait_confirm(40, cyc, seen);
        check_eq("t0_confirm_seen", 64'(seen), 64'd1);
        check_eq("t0_latency",      64'(cyc), 64'd18);
        check_eq("t0_timeout_err",  64'(timeout_err), 64'd1);
        check_eq("t0_rd_data_kept", req_bus.rd_data, 64'hDEAD_BEEF_0000_FFFF);
        check_eq("t0_maxlat_kept",  64'(max_rd_latency), stat(64'd5));
        check_eq("t0_rd_count",     64'(rd_count), stat(64'd2));
        req_bus.req_read = 1'b0;
        @(negedge clk);
        avm_bus.avm_readdatavalid = 1'b1;
        avm_bus.avm_readdata      = 64'h1111_2222_3333_4444;
        repeat (2) @(negedge clk);
        avm_bus.avm_readdatavalid = 1'b0;
        check_eq("t0_stray_ignored", req_bus.rd_data, 64'hDEAD_BEEF_0000_FFFF);
        check_eq("t0_stray_idle",    64'(bridge_state), 64'd0);
        check_eq("t0_stray_noconf",  64'(req_bus.confirm), 64'd0);

        // ---------------- read and write together ----------------
        check_eq("p0_proto_before", 64'(proto_err), 64'd0);
        req_bus.req_read    = 1'b1;
        req_bus.req_write   = 1'b1;
        req_bus.req_address = 64'h55;
        req_bus.req_wdata   = 64'h77;
        @(negedge clk);
        check_eq("p0_write_wins",  64'({avm_bus.avm_write, avm_bus.avm_read}), 64'b10);
        check_eq("p0_state",       64'(bridge_state), 64'd1);
        @(negedge clk);
        check_eq("p0_confirm",     64'(req_bus.confirm), 64'd1);
        check_eq("p0_proto_err",   64'(proto_err), 64'd1);
        check_eq("p0_wr_count",    64'(wr_count), stat(64'd3));
        req_bus.req_read  = 1'b0;
        req_bus.req_write = 1'b0;
        @(negedge clk);
        do_write(64'h99, 64'hCAFE, "p1");
        @(negedge clk);
        check_eq("p1_proto_sticky", 64'(proto_err), 64'd1);
        check_eq("p1_tmo_sticky",   64'(timeout_err), 64'd1);
        check_eq("p1_wr_count",     64'(wr_count), stat(64'd4));

        // ---------------- reset during WAIT_RD ----------------
        req_bus.req_read    = 1'b1;
        req_bus.req_address = 64'h100;
        repeat (3) @(negedge clk);
        check_eq("x0_in_wait", 64'(bridge_state), 64'd3);
        reset_n = 1'b0;
        #1;
        check_eq("x0_state",   64'(bridge_state), 64'd0);
        check_eq("x0_confirm", 64'(req_bus.confirm), 64'd0);
        check_eq("x0_rdwr",    64'({avm_bus.avm_read, avm_bus.avm_write}), 64'd0);
        check_eq("x0_errs",    64'({timeout_err, proto_err}), 64'd0);
        check_eq("x0_rd_data", req_bus.rd_data, 64'd0);
        check_eq("x0_addr",    64'(avm_bus.avm_address), 64'd0);
        check_eq("x0_counts",  {wr_count, rd_count}, 64'd0);
        req_bus.req_read = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("x0_no_confirm_after", 64'(req_bus.confirm), 64'd0);

        // Next read after release: data lands on the timeout cycle and wins.
        req_bus.req_read    = 1'b1;
        req_bus.req_address = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        check_eq("x1_avm_read", 64'(avm_bus.avm_read), 64'd1);
        check_eq("x1_addr",     64'(avm_bus.avm_address), 64'h3FF_FFFF);
        for (int c = 2; c <= 17; c++) begin
            @(negedge clk);
            check_eq($sformatf("x1_noconf_c%0d", c), 64'(req_bus.confirm), 64'd0);
            if (c == 17) begin
                avm_bus.avm_readdatavalid = 1'b1;
                avm_bus.avm_readdata      = 64'h0F0F_F0F0_5A5A_A5A5;
            end
        end
        @(negedge clk);
        avm_bus.avm_readdatavalid = 1'b0;
        check_eq("x1_confirm",  64'(req_bus.confirm), 64'd1);
        check_eq("x1_rd_data",  req_bus.rd_data, 64'h0F0F_F0F0_5A5A_A5A5);
        check_eq("x1_no_tmo",   64'(timeout_err), 64'd0);
        check_eq("x1_maxlat",   64'(max_rd_latency), stat(64'd16));
        check_eq("x1_rd_count", 64'(rd_count), stat(64'd1));
        req_bus.req_read = 1'b0;
        @(negedge clk);
        check_eq("x1_idle", 64'(bridge_state), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
